alu_decode_stage: RTL and testbench

- Pipelined decode stage that turns a fetched RV32I instruction into the 4-bit `ALUControl` encoding, the sign-extended immediate and the register indices the ALU datapath consumes.
- Sits between fetch and execute as the producing end of the ALU control interface.
- Holds one registered result behind a valid/ready handshake, with a synchronous flush for branch redirects.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/imm_gen.sv | 30 +++
 rtl/alu_decode_stage.sv | 211 +++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU decode types: ALUControl encodings, RV32I opcodes, immediate formats.
// Pure declarations; no latency or backpressure of its own.
// Imported by alu_decode_stage and imm_gen.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_AUIPC = 4'b1010,
    ALU_LUI   = 4'b1011,
    ALU_LINK  = 4'b1100
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // alt selects sub for funct3 000 and sra for funct3 101
  function automatic alu_ctrl_t alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for I/S/B/U/J formats, sign-extended from instr[31].
// Combinational, zero latency.
// No handshake; follows its inputs.
module imm_gen
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:7]           instr,
  input  imm_type_t             imm_type,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage producing ALUControl, immediate and register fields (skid: ALU_DECODE_SKID_EN).
// Latency: 1 cycle from input transfer to OutValid.
// Backpressure: InReady = !OutValid || OutReady; with skid, registered and 1 while skid entry empty.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     InstrD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      Flush,
  input  logic                      OutReady,
  output logic                      OutValid,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ALUSrcBE,
  output logic                      RegWriteE,
  output logic                      IllegalE
);

  typedef struct packed {
    logic [ALU_CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      srcb;
    logic                      regwrite;
    logic                      illegal;
  } dec_t;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  alu_ctrl_t             ctrl;
  imm_type_t             imm_sel;
  logic                  imm_en;
  logic                  srcb;
  logic                  regwrite;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] imm_raw;
  dec_t                  dec_d;
  dec_t                  out_q;
  logic                  out_vld;
  logic                  in_xfer;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .instr    (InstrD[31:7]),
    .imm_type (imm_sel),
    .imm      (imm_raw)
  );

  always_comb begin
    ctrl     = ALU_ADD;
    imm_sel  = IMM_I;
    imm_en   = 1'b0;
    srcb     = 1'b0;
    regwrite = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          ctrl     = alu_op(funct3, funct7[5]);
          regwrite = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        ctrl     = alu_op(funct3, funct7[5] && funct3 == 3'b101);
        imm_en   = 1'b1;
        srcb     = 1'b1;
        regwrite = 1'b1;
      end
      OP_LOAD: begin
        imm_en   = 1'b1;
        srcb     = 1'b1;
        regwrite = 1'b1;
      end
      OP_STORE: begin
        imm_sel = IMM_S;
        imm_en  = 1'b1;
        srcb    = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel = IMM_B;
        imm_en  = 1'b1;
        case (funct3)
          3'b000, 3'b001: ctrl = ALU_SUB;
          3'b100, 3'b101: ctrl = ALU_SLT;
          3'b110, 3'b111: ctrl = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      OP_LUI, OP_AUIPC: begin
        ctrl     = (opcode == OP_LUI) ? ALU_LUI : ALU_AUIPC;
        imm_sel  = IMM_U;
        imm_en   = 1'b1;
        srcb     = 1'b1;
        regwrite = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        ctrl     = ALU_LINK;
        imm_sel  = (opcode == OP_JAL) ? IMM_J : IMM_I;
        imm_en   = 1'b1;
        srcb     = 1'b1;
        regwrite = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // illegal words travel on as a harmless add with no side effects
    if (illegal) begin
      ctrl     = ALU_ADD;
      imm_en   = 1'b0;
      srcb     = 1'b0;
      regwrite = 1'b0;
    end
  end

  always_comb begin
    dec_d          = '0;
    dec_d.ctrl     = ALU_CTRL_WIDTH'(ctrl);
    dec_d.imm      = imm_en ? imm_raw : '0;
    dec_d.pc       = PCD;
    dec_d.rs1      = REG_ADDR_WIDTH'(InstrD[19:15]);
    dec_d.rs2      = REG_ADDR_WIDTH'(InstrD[24:20]);
    dec_d.rd       = REG_ADDR_WIDTH'(InstrD[11:7]);
    dec_d.srcb     = srcb;
    dec_d.regwrite = regwrite;
    dec_d.illegal  = illegal;
  end

  assign in_xfer = InValid && InReady;

`ifdef ALU_DECODE_SKID_EN
  logic skid_empty;
  dec_t skid_q;

  assign InReady = skid_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld    <= 1'b0;
      out_q      <= '0;
      skid_empty <= 1'b1;
      skid_q     <= '0;
    end else if (Flush) begin
      out_vld    <= 1'b0;
      skid_empty <= 1'b1;
    end else if (!skid_empty) begin
      // skid full implies output full and input blocked
      if (OutReady) begin
        out_q      <= skid_q;
        skid_empty <= 1'b1;
      end
    end else if (!out_vld || OutReady) begin
      out_vld <= in_xfer;
      if (in_xfer) out_q <= dec_d;
    end else if (in_xfer) begin
      skid_q     <= dec_d;
      skid_empty <= 1'b0;
    end
  end
`else
  logic out_xfer;

  assign InReady  = !out_vld || OutReady;
  assign out_xfer = out_vld && OutReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (Flush) begin
      out_vld <= 1'b0;
    end else if (in_xfer) begin
      out_vld <= 1'b1;
      out_q   <= dec_d;
    end else if (out_xfer) begin
      out_vld <= 1'b0;
    end
  end
`endif

  assign OutValid    = out_vld;
  assign ALUControlE = out_q.ctrl;
  assign ImmExtE     = out_q.imm;
  assign PCE         = out_q.pc;
  assign Rs1E        = out_q.rs1;
  assign Rs2E        = out_q.rs2;
  assign RdE         = out_q.rd;
  assign ALUSrcBE    = out_q.srcb;
  assign RegWriteE   = out_q.regwrite;
  assign IllegalE    = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed instructions, stall, flush and reset.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        srcb;
    logic        rw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD;
  logic        InValid, InReady, Flush, OutReady, OutValid;
  logic [3:0]  ALUControlE;
  logic [31:0] ImmExtE, PCE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ALUSrcBE, RegWriteE, IllegalE;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] pc_n = 32'h0000_1000;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .InValid(InValid),
    .InReady(InReady), .Flush(Flush), .OutReady(OutReady), .OutValid(OutValid),
    .ALUControlE(ALUControlE), .ImmExtE(ImmExtE), .PCE(PCE), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE), .ALUSrcBE(ALUSrcBE), .RegWriteE(RegWriteE),
    .IllegalE(IllegalE)
  );

  function automatic exp_t act_now();
    return {ALUControlE, ImmExtE, PCE, Rs1E, Rs2E, RdE, ALUSrcBE, RegWriteE, IllegalE};
  endfunction

  function automatic exp_t mk(logic [3:0] c, logic [31:0] imm, logic [4:0] r1,
                              logic [4:0] r2, logic [4:0] rd, logic s, logic w, logic i);
    return {c, imm, 32'h0, r1, r2, rd, s, w, i};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // scoreboard monitor: outputs are consumed at the posedge following a negedge with OutValid && OutReady
  always @(negedge clk) begin
    if (!rst) begin
      if (Flush) begin
        exp_q.delete();
      end else if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got pc %0h instr-ctrl %0h required no output", PCE, ALUControlE);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out", 128'(act_now()), 128'(mon_e));
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input exp_t e);
    bit acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      InValid = 1'b1; InstrD = ins; PCD = pc_n; Flush = 1'b0; OutReady = 1'b1;
      @(negedge clk);
      if (InReady) begin
        acc = 1;
        e.pc = pc_n;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    InValid = 1'b0;
    pc_n = pc_n + 32'd4;
  endtask

  initial begin
    exp_t snap;
    exp_t ea;
    rst = 1'b1; InstrD = '0; PCD = '0; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outvalid", OutValid, 0);
    chk("rst_outputs", 128'(act_now()), 0);
    chk("rst_inready", InReady, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back directed stream
    send(32'h40B50533, mk(4'b0001, 32'h0,        10, 11, 10, 0, 1, 0)); // sub
    send(32'hFFF00093, mk(4'b0000, 32'hFFFFFFFF,  0, 31,  1, 1, 1, 0)); // addi -1
    send(32'h123452B7, mk(4'b1011, 32'h12345000,  8,  3,  5, 1, 1, 0)); // lui
    send(32'h4041D193, mk(4'b0111, 32'h00000404,  3,  4,  3, 1, 1, 0)); // srai 4
    send(32'h00000000, mk(4'b0000, 32'h0,         0,  0,  0, 0, 0, 1)); // illegal opcode
    send(32'h0020A423, mk(4'b0000, 32'h00000008,  1,  2,  8, 1, 0, 0)); // sw 8(x1)
    send(32'hFE208EE3, mk(4'b0001, 32'hFFFFFFFC,  1,  2, 29, 0, 0, 0)); // beq -4
    send(32'h0020A063, mk(4'b0000, 32'h0,         1,  2,  0, 0, 0, 1)); // branch f3=010
    send(32'h02B50533, mk(4'b0000, 32'h0,        10, 11, 10, 0, 0, 1)); // bad funct7
    send(32'hFF9FF0EF, mk(4'b1100, 32'hFFFFFFF8, 31, 25,  1, 1, 1, 0)); // jal -8
    send(32'hFFFFF197, mk(4'b1010, 32'hFFFFF000, 31, 31,  3, 1, 1, 0)); // auipc
    InValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stream_drained", exp_q.size(), 0);

    // stall: first word lands on the output, a second word is presented
    OutReady = 1'b0;
    send(32'h40B50533, mk(4'b0001, 32'h0, 10, 11, 10, 0, 1, 0));
    OutReady = 1'b0;
    chk("stall_outvalid", OutValid, 1);
    snap = act_now();
    for (int k = 0; k < 3; k++) begin
      InValid = 1'b1; InstrD = 32'hFFF00093; PCD = 32'h0000_2000; OutReady = 1'b0; Flush = 1'b0;
      @(negedge clk);
      chk("stall_stable", 128'(act_now()), 128'(snap));
`ifdef ALU_DECODE_SKID_EN
      chk("stall_inready", InReady, (k == 0) ? 1 : 0);
`else
      chk("stall_inready", InReady, 0);
`endif
      if (InReady) begin
        ea = mk(4'b0000, 32'hFFFFFFFF, 0, 31, 1, 1, 1, 0);
        ea.pc = 32'h0000_2000;
        exp_q.push_back(ea);
      end
      @(posedge clk); #1;
    end

    // flush with a simultaneous input: nothing of it may ever reach the output
    InValid = 1'b1; InstrD = 32'h123452B7; PCD = 32'h0000_3000; Flush = 1'b1; OutReady = 1'b0;
    @(posedge clk); #1;
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    chk("flush_outvalid", OutValid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_flush_idle", OutValid, 0);
    end
    @(posedge clk); #1;
    send(32'h4041D193, mk(4'b0111, 32'h00000404, 3, 4, 3, 1, 1, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("flush_recovered", exp_q.size(), 0);

    // reset in the middle of a stall
    OutReady = 1'b0;
    send(32'hFFF00093, mk(4'b0000, 32'hFFFFFFFF, 0, 31, 1, 1, 1, 0));
    OutReady = 1'b0;
    chk("pre_rst_outvalid", OutValid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_outvalid", OutValid, 0);
    chk("rst_mid_outputs", 128'(act_now()), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; OutReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_idle", OutValid, 0);
    end
    @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
